picorv32_pcpi_dispatch: RTL and testbench
=========================================

PICORV32_PCPI_DISPATCH -- requirements
Module: picorv32_pcpi_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of BUSY cycles with no wait/ready from any port before timeout; legal range 2..255.
REQ-002 SHALL have parameter ENABLE_P1, default 1, meaning coprocessor port 1 is present; when 0, p1_valid is held 0 and all p1 inputs are ignored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports pcpi_valid (1), pcpi_insn (32), pcpi_rs1 (32) and pcpi_rs2 (32), all inputs: the core request.
REQ-006 SHALL have ports pcpi_int_ready (1), pcpi_int_wait (1), pcpi_int_wr (1) and pcpi_int_rd (32), all outputs: the response to the core.
REQ-007 SHALL have port pcpi_int_timeout, output, 1 bit: one-cycle pulse; the instruction was claimed by no port.
REQ-008 SHALL have, for each port x in {0,1}, outputs px_valid (1), px_insn (32), px_rs1 (32) and px_rs2 (32): the broadcast request.
REQ-009 SHALL have, for each port x in {0,1}, inputs px_ready (1), px_wait (1), px_wr (1) and px_rd (32): the coprocessor response.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, RESP and RELEASE, encoded in 2 bits.
REQ-011 IDLE: when pcpi_valid=1, SHALL latch insn/rs1/rs2, clear the counter, go to BUSY; p0_valid/p1_valid SHALL be 1 from the next cycle on.
REQ-012 px_insn/px_rs1/px_rs2 SHALL be driven from the latched registers only, stable for the whole of BUSY.
REQ-013 BUSY, priority order: pcpi_valid=0 abort; p0_ready; p1_ready (if ENABLE_P1); timeout; otherwise stay.
REQ-014 Abort: SHALL go to IDLE; px_valid SHALL drop the next cycle; no ready/timeout pulse; pcpi_int_rd unchanged.
REQ-015 On a ready: SHALL capture the winner's rd/wr into pcpi_int_rd/pcpi_int_wr and go to RESP; px_valid SHALL drop the next cycle; if both ready in the same cycle, p0 SHALL win and p1's result is discarded.
REQ-016 The counter SHALL be cleared every BUSY cycle that has any enabled px_wait=1; otherwise it SHALL increment (8-bit, saturating).
REQ-017 pcpi_int_wait SHALL be combinational: (state==BUSY) and (p0_wait or (ENABLE_P1 and p1_wait)).
REQ-018 Timeout: when the counter equals TIMEOUT_CYCLES-1 and no wait/ready is present that cycle, SHALL set pcpi_int_rd=0 and pcpi_int_wr=0, flag timeout, and go to RESP.
REQ-019 RESP, exactly one cycle: pcpi_int_ready=1 (normal) or pcpi_int_timeout=1 (timeout), never both; then go to RELEASE.
REQ-020 RELEASE: SHALL stay while pcpi_valid=1 and go to IDLE when pcpi_valid=0; no new request is accepted in RELEASE.
REQ-021 Latency: px_ready at cycle N SHALL give pcpi_int_ready at N+1; pcpi_valid rising at cycle 0 SHALL give px_valid at cycle 1.
REQ-022 px_ready/px_wait SHALL be ignored in IDLE, RESP and RELEASE.
REQ-023 pcpi_int_rd/pcpi_int_wr SHALL hold their value until the next capture or timeout.

Reset
REQ-024 resetn=0 SHALL immediately force: state IDLE, counter 0, latched operands 0, all outputs 0 (px_valid, pcpi_int_ready, pcpi_int_wait, pcpi_int_wr, pcpi_int_rd, pcpi_int_timeout).
REQ-025 Reset asserted in any state SHALL abort the transaction with no ready/timeout pulse; the first request is accepted on the first edge after resetn=1.

Verification
REQ-026 Basic: valid with insn=0x02B50533, rs1=6, rs2=7; p0 wait 3 cycles then ready with rd=42, wr=1 -> pcpi_int_ready one cycle, rd=42, wr=1; p0_valid low the cycle after ready.
REQ-027 Collision: p0_ready (rd=0x11) and p1_ready (rd=0x22) in the same cycle -> pcpi_int_rd=0x11, single ready pulse.
REQ-028 Timeout: TIMEOUT_CYCLES=16, no port responds -> pcpi_int_timeout at BUSY cycle 17, rd=0, wr=0, no ready; with p1_wait held 40 cycles then p1_ready, no timeout occurs.
REQ-029 Abort: pcpi_valid drops at BUSY cycle 2, p0_ready at cycle 3 -> no ready pulse, state IDLE, pcpi_int_rd unchanged.
REQ-030 ENABLE_P1=0: p1_ready=1 with rd=0x55 -> ignored, p1_valid stays 0; timeout fires.
REQ-031 Async reset mid-BUSY -> outputs 0 in the same cycle; new request after resetn=1 completes normally; RELEASE holds while pcpi_valid stays 1 for 5 cycles.

Source files
------------

// File: rtl/picorv32_pcpi_dispatch.sv
// PCPI dispatcher: broadcasts one core PCPI request to two coprocessor ports,
// forwards the first responder's result and raises a timeout if nobody claims it.
module picorv32_pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ENABLE_P1      = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_int_ready,
  output logic        pcpi_int_wait,
  output logic        pcpi_int_wr,
  output logic [31:0] pcpi_int_rd,
  output logic        pcpi_int_timeout,

  output logic        p0_valid,
  output logic [31:0] p0_insn,
  output logic [31:0] p0_rs1,
  output logic [31:0] p0_rs2,
  input  logic        p0_ready,
  input  logic        p0_wait,
  input  logic        p0_wr,
  input  logic [31:0] p0_rd,

  output logic        p1_valid,
  output logic [31:0] p1_insn,
  output logic [31:0] p1_rs1,
  output logic [31:0] p1_rs2,
  input  logic        p1_ready,
  input  logic        p1_wait,
  input  logic        p1_wr,
  input  logic [31:0] p1_rd
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_insn;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_rd;
  logic        r_wr;
  logic        r_to;

  logic w_p1_en;
  logic w_busy;
  logic w_p1_ready;
  logic w_any_wait;
  logic w_timeout_hit;

  // Port 1 handshakes are masked at the source so a disabled port can never win.
  assign w_p1_en       = (ENABLE_P1 != 0);
  assign w_busy        = (r_state == S_BUSY);
  assign w_p1_ready    = w_p1_en & p1_ready;
  assign w_any_wait    = p0_wait | (w_p1_en & p1_wait);
  assign w_timeout_hit = (r_cnt == TO_LAST) && !w_any_wait;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering inside the block is moot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_insn  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pcpi_valid) begin
            r_insn  <= pcpi_insn;
            r_rs1   <= pcpi_rs1;
            r_rs2   <= pcpi_rs2;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!pcpi_valid) begin
            r_state <= S_IDLE;
          end else if (p0_ready) begin
            r_rd    <= p0_rd;
            r_wr    <= p0_wr;
            r_to    <= 1'b0;
            r_state <= S_RESP;
          end else if (w_p1_ready) begin
            r_rd    <= p1_rd;
            r_wr    <= p1_wr;
            r_to    <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout_hit) begin
            r_rd    <= '0;
            r_wr    <= 1'b0;
            r_to    <= 1'b1;
            r_state <= S_RESP;
          end else if (w_any_wait) begin
            r_cnt <= '0;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_RELEASE;
        end
        default: begin
          // Hold until the core drops valid so the same instruction is not re-issued.
          if (!pcpi_valid) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_valid = w_busy;
  assign p0_insn  = r_insn;
  assign p0_rs1   = r_rs1;
  assign p0_rs2   = r_rs2;

  assign p1_valid = w_busy & w_p1_en;
  assign p1_insn  = r_insn;
  assign p1_rs1   = r_rs1;
  assign p1_rs2   = r_rs2;

  assign pcpi_int_ready   = (r_state == S_RESP) & ~r_to;
  assign pcpi_int_timeout = (r_state == S_RESP) &  r_to;
  assign pcpi_int_wait    = w_busy & w_any_wait;
  assign pcpi_int_rd      = r_rd;
  assign pcpi_int_wr      = r_wr;

endmodule

// File: tb/tb_picorv32_pcpi_dispatch.sv
// Directed bench for picorv32_pcpi_dispatch: u_dut has both ports enabled,
// u_dut1 shares all inputs but is built with port 1 disabled.
module tb_picorv32_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        p0_ready, p0_wait, p0_wr;
  logic [31:0] p0_rd;
  logic        p1_ready, p1_wait, p1_wr;
  logic [31:0] p1_rd;

  logic        int_ready, int_wait, int_wr, int_timeout;
  logic [31:0] int_rd;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_insn, p0_rs1, p0_rs2, p1_insn, p1_rs1, p1_rs2;

  logic        b_ready, b_wait, b_wr, b_timeout;
  logic [31:0] b_rd;
  logic        b_p0_valid, b_p1_valid;
  logic [31:0] b_p0_insn, b_p0_rs1, b_p0_rs2, b_p1_insn, b_p1_rs1, b_p1_rs2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  picorv32_pcpi_dispatch #(.TIMEOUT_CYCLES(16), .ENABLE_P1(1)) u_dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_int_ready(int_ready), .pcpi_int_wait(int_wait), .pcpi_int_wr(int_wr),
    .pcpi_int_rd(int_rd), .pcpi_int_timeout(int_timeout),
    .p0_valid(p0_valid), .p0_insn(p0_insn), .p0_rs1(p0_rs1), .p0_rs2(p0_rs2),
    .p0_ready(p0_ready), .p0_wait(p0_wait), .p0_wr(p0_wr), .p0_rd(p0_rd),
    .p1_valid(p1_valid), .p1_insn(p1_insn), .p1_rs1(p1_rs1), .p1_rs2(p1_rs2),
    .p1_ready(p1_ready), .p1_wait(p1_wait), .p1_wr(p1_wr), .p1_rd(p1_rd)
  );

  picorv32_pcpi_dispatch #(.TIMEOUT_CYCLES(16), .ENABLE_P1(0)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_int_ready(b_ready), .pcpi_int_wait(b_wait), .pcpi_int_wr(b_wr),
    .pcpi_int_rd(b_rd), .pcpi_int_timeout(b_timeout),
    .p0_valid(b_p0_valid), .p0_insn(b_p0_insn), .p0_rs1(b_p0_rs1), .p0_rs2(b_p0_rs2),
    .p0_ready(p0_ready), .p0_wait(p0_wait), .p0_wr(p0_wr), .p0_rd(p0_rd),
    .p1_valid(b_p1_valid), .p1_insn(b_p1_insn), .p1_rs1(b_p1_rs1), .p1_rs2(b_p1_rs2),
    .p1_ready(p1_ready), .p1_wait(p1_wait), .p1_wr(p1_wr), .p1_rd(p1_rd)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // One clock: inputs set afterwards belong to the next edge; outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ports();
    p0_ready = 0; p0_wait = 0; p0_wr = 0; p0_rd = '0;
    p1_ready = 0; p1_wait = 0; p1_wr = 0; p1_rd = '0;
  endtask

  task automatic idle(input int n);
    pcpi_valid = 0;
    clear_ports();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    pcpi_valid = 1; pcpi_insn = insn; pcpi_rs1 = rs1; pcpi_rs2 = rs2;
  endtask

  initial begin
    logic bad;
    resetn = 0;
    pcpi_valid = 0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    clear_ports();
    p0_wait = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_p0_valid", 32'(p0_valid), 0);
    check("rst_p1_valid", 32'(p1_valid), 0);
    check("rst_int_wait", 32'(int_wait), 0);
    check("rst_int_ready", 32'(int_ready), 0);
    check("rst_int_rd", int_rd, 0);
    check("rst_timeout", 32'(int_timeout), 0);
    p0_wait = 0;
    @(negedge clk);
    resetn = 1;
    tick();

    // Basic: p0 waits 3 cycles then returns 42
    request(32'h02B50533, 32'd6, 32'd7);
    #1;
    check("basic_valid_pre", 32'(p0_valid), 0);
    tick();
    check("basic_p0_valid", 32'(p0_valid), 1);
    check("basic_p1_valid", 32'(p1_valid), 1);
    check("basic_p0_insn", p0_insn, 32'h02B50533);
    check("basic_p0_rs1", p0_rs1, 32'd6);
    check("basic_p1_rs2", p1_rs2, 32'd7);
    p0_wait = 1;
    #1;
    check("basic_int_wait", 32'(int_wait), 1);
    repeat (3) tick();
    p0_wait = 0; p0_ready = 1; p0_rd = 32'd42; p0_wr = 1;
    #1;
    check("basic_ready_pre", 32'(int_ready), 0);
    tick();
    clear_ports();
    check("basic_ready", 32'(int_ready), 1);
    check("basic_rd", int_rd, 32'd42);
    check("basic_wr", 32'(int_wr), 1);
    check("basic_p0_drop", 32'(p0_valid), 0);
    check("basic_no_timeout", 32'(int_timeout), 0);
    tick();
    check("basic_ready_once", 32'(int_ready), 0);
    check("basic_rd_hold", int_rd, 32'd42);
    idle(3);

    // Collision: p0 wins
    request(32'h0000_1234, 32'd1, 32'd2);
    tick();
    p0_ready = 1; p0_rd = 32'h11; p0_wr = 1;
    p1_ready = 1; p1_rd = 32'h22; p1_wr = 0;
    tick();
    clear_ports();
    check("coll_ready", 32'(int_ready), 1);
    check("coll_rd", int_rd, 32'h11);
    check("coll_wr", 32'(int_wr), 1);
    tick();
    check("coll_single_pulse", 32'(int_ready), 0);
    idle(3);

    // Timeout: nobody answers; pulse lands on BUSY cycle 17
    request(32'h0000_00FF, 32'd3, 32'd4);
    tick();
    repeat (15) tick();
    check("to_not_yet", 32'(int_timeout), 0);
    check("to_still_busy", 32'(p0_valid), 1);
    tick();
    check("to_pulse", 32'(int_timeout), 1);
    check("to_no_ready", 32'(int_ready), 0);
    check("to_rd_zero", int_rd, 0);
    check("to_wr_zero", 32'(int_wr), 0);
    tick();
    check("to_pulse_once", 32'(int_timeout), 0);
    idle(3);

    // p1 waits 40 cycles then answers: no timeout on the two-port instance
    request(32'h0000_0ABC, 32'd5, 32'd6);
    tick();
    p1_wait = 1;
    #1;
    check("wait_p1_int_wait", 32'(int_wait), 1);
    check("wait_p1_disabled_wait", 32'(b_wait), 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int_timeout !== 1'b0 || p0_valid !== 1'b1) bad = 1;
    end
    check("wait_no_timeout", 32'(bad), 0);
    p1_wait = 0; p1_ready = 1; p1_rd = 32'h77; p1_wr = 1;
    tick();
    clear_ports();
    check("wait_p1_ready", 32'(int_ready), 1);
    check("wait_p1_rd", int_rd, 32'h77);
    idle(3);

    // Abort at BUSY cycle 2, late p0_ready ignored
    request(32'h0000_0F0F, 32'd8, 32'd9);
    tick();
    tick();
    pcpi_valid = 0;
    tick();
    p0_ready = 1; p0_rd = 32'h99; p0_wr = 0;
    #1;
    check("abort_valid_drop", 32'(p0_valid), 0);
    tick();
    clear_ports();
    check("abort_no_ready", 32'(int_ready), 0);
    check("abort_rd_kept", int_rd, 32'h77);
    check("abort_idle", 32'(p0_valid), 0);
    idle(3);

    // Port 1 disabled: its ready is ignored and the request times out
    request(32'h0000_5555, 32'd10, 32'd11);
    tick();
    check("p1off_p1_valid", 32'(b_p1_valid), 0);
    check("p1off_p0_valid", 32'(b_p0_valid), 1);
    p1_ready = 1; p1_rd = 32'h55; p1_wr = 1;
    repeat (15) tick();
    check("p1off_no_ready", 32'(b_ready), 0);
    check("p1off_not_yet", 32'(b_timeout), 0);
    tick();
    check("p1off_timeout", 32'(b_timeout), 1);
    check("p1off_rd", b_rd, 0);
    idle(3);

    // Async reset in BUSY, then a clean transaction and a long RELEASE
    request(32'hCAFE_0001, 32'd12, 32'd13);
    tick();
    tick();
    p0_wait = 1;
    #1;
    check("rstmid_busy", 32'(p0_valid), 1);
    #1;
    resetn = 0;
    #1;
    check("rstmid_valid", 32'(p0_valid), 0);
    check("rstmid_wait", 32'(int_wait), 0);
    check("rstmid_rd", int_rd, 0);
    check("rstmid_insn", p0_insn, 0);
    p0_wait = 0;
    @(negedge clk);
    resetn = 1;
    tick();
    check("rstmid_accept", 32'(p0_valid), 1);
    check("rstmid_insn_new", p0_insn, 32'hCAFE_0001);
    p0_ready = 1; p0_rd = 32'hABCD; p0_wr = 0;
    tick();
    clear_ports();
    check("rstmid_ready", 32'(int_ready), 1);
    check("rstmid_rd_new", int_rd, 32'hABCD);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (p0_valid !== 1'b0 || int_ready !== 1'b0) bad = 1;
    end
    check("release_hold", 32'(bad), 0);
    pcpi_valid = 0;
    tick();
    tick();
    check("release_idle", 32'(p0_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
